// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises six IRQ lines, latches edge/level pending
// bits, masks and prioritises them with in-service nesting, and drives a
// registered one-hot HWInt[7:2] request plus a vector/EOI register window.
module int_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20,
  parameter int unsigned N_SRC     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [29:0]      PrAddr,
  input  logic [31:0]      PrWD,
  input  logic             PrWe,
  input  logic             PrRe,
  input  logic [3:0]       BE,
  output logic [31:0]      PrRD,
  input  logic [N_SRC-1:0] irq_in,
  output logic [N_SRC-1:0] HWInt
);

  localparam int unsigned AW    = 30;
  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 3;
  localparam int unsigned N_REG = 6;

  localparam logic [AW-1:0] BASE_W = BASE_ADDR[31:2];

  localparam logic [2:0] OFF_PEND = 3'd0;
  localparam logic [2:0] OFF_MASK = 3'd1;
  localparam logic [2:0] OFF_MODE = 3'd2;
  localparam logic [2:0] OFF_ACK  = 3'd3;
  localparam logic [2:0] OFF_VEC  = 3'd4;
  localparam logic [2:0] OFF_EOI  = 3'd5;

  // Isolates the lowest set bit (index 0 is the highest priority).
  function automatic logic [N_SRC-1:0] lowest(input logic [N_SRC-1:0] x);
    return x & (~x + N_SRC'(1));
  endfunction

  logic [N_SRC-1:0] sync1_q, sync1_d;
  logic [N_SRC-1:0] sync2_q, sync2_d;
  logic [N_SRC-1:0] prev_q,  prev_d;
  logic [N_SRC-1:0] pend_q,  pend_d;
  logic [N_SRC-1:0] mask_q,  mask_d;
  logic [N_SRC-1:0] mode_q,  mode_d;
  logic [N_SRC-1:0] isr_q,   isr_d;
  logic [N_SRC-1:0] hwint_q, hwint_d;

  logic [AW-1:0]    addr_off;
  logic             hit;
  logic [2:0]       sel;
  logic             wr;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend_eff;
  logic             vec_valid;
  logic [IW-1:0]    vec_idx;
  logic [N_SRC-1:0] acc_oh;
  logic [N_SRC-1:0] eoi_oh;
  logic [N_SRC-1:0] ack_bits;
  logic [N_SRC-1:0] below_top;
  logic [N_SRC-1:0] elig;

  logic unused_ok;
  assign unused_ok = ^{PrWD[DW-1:N_SRC], BE[3:1]};

  // Address decode and bus write qualification.
  always_comb begin
    addr_off = PrAddr - BASE_W;
    hit      = (addr_off < AW'(N_REG));
    sel      = addr_off[2:0];
    wr       = PrWe & BE[0] & hit;
  end

  // Pending view: edge bits come from the latch, level bits track the synchronised line.
  always_comb begin
    rise     = sync2_q & ~prev_q;
    pend_eff = (pend_q & mode_q) | (sync2_q & ~mode_q);
    vec_valid = |hwint_q;
    vec_idx   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (hwint_q[i]) vec_idx = IW'(i);
    end
  end

  // Next-state for synchronisers, registers, pending, in-service and HWInt.
  always_comb begin
    sync1_d  = irq_in;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    mask_d   = mask_q;
    mode_d   = mode_q;
    ack_bits = '0;
    acc_oh   = '0;
    eoi_oh   = '0;

    if (wr && sel == OFF_MASK) mask_d   = PrWD[N_SRC-1:0];
    if (wr && sel == OFF_MODE) mode_d   = PrWD[N_SRC-1:0];
    if (wr && sel == OFF_ACK)  ack_bits = PrWD[N_SRC-1:0];
    if (wr && sel == OFF_EOI)  eoi_oh   = lowest(isr_q);
    if (PrRe && hit && sel == OFF_VEC && vec_valid) acc_oh = hwint_q;

    // A rising edge in the same cycle as a clear keeps the bit set.
    pend_d = (mode_q & (rise | (pend_q & ~(ack_bits | acc_oh)))) |
             (~mode_q & sync2_q);

    // EOI retires the current top first, then acceptance marks the new one.
    isr_d = (isr_q & ~eoi_oh) | acc_oh;

    // Only sources above the highest in-service level may interrupt; all when idle.
    below_top = lowest(isr_d) - N_SRC'(1);
    elig      = pend_eff & mask_q & below_top;
    hwint_d   = lowest(elig);
  end

  // Read mux, combinational from the address.
  always_comb begin
    PrRD = '0;
    if (hit) begin
      case (sel)
        OFF_PEND: PrRD = DW'(pend_eff);
        OFF_MASK: PrRD = DW'(mask_q);
        OFF_MODE: PrRD = DW'(mode_q);
        OFF_VEC:  PrRD = {vec_valid, (DW - 1 - IW)'(0), vec_idx};
        default:  PrRD = '0;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '1;
      isr_q   <= '0;
      hwint_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      isr_q   <= isr_d;
      hwint_q <= hwint_d;
    end
  end

  assign HWInt = hwint_q;

endmodule
